sram_stream_reader: RTL



---
 rtl/sram_stream_reader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sram_stream_reader.sv
// ---------------------------------------------------------------------------
// sram_stream_reader
//
// Avalon-MM read initiator for one port of the NPU's 4096 x 16-bit dual-port
// on-chip SRAM.
// - Takes a (start address, length) command.
// - Issues single-word reads to the SRAM port.
// - Returns the words in order on a valid/ready stream, with a last-beat marker.
//
// Ports:
//   clk, reset         single clock; synchronous active-high reset
//   cmd_valid/ready    command handshake; cmd_addr = first word,
//                      cmd_len = word count (0..2**ADDR_W)
//   sram_*             SRAM read port (read strobe = sram_chipselect;
//                      readdata is valid the cycle after the strobe)
//   out_valid/ready    output stream handshake; out_data = word,
//                      out_last = final word of the command
//   busy               a command is in progress
//   done               one-cycle pulse when a command completes
// ---------------------------------------------------------------------------
module sram_stream_reader #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [ADDR_W:0]     cmd_len,
   output logic [ADDR_W-1:0]   sram_address,
   output logic                sram_chipselect,
   output logic                sram_write,
   output logic [DATA_W/8-1:0] sram_byteenable,
   input  logic [DATA_W-1:0]   sram_readdata,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_last,
   output logic                busy,
   output logic                done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LEN_W = ADDR_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   addr_reg;          // next address to issue
   logic [LEN_W-1:0]    remaining_reg;     // reads still to issue
   logic                cs_reg;            // read strobe for this cycle
   logic                cs_last_reg;       // this strobe is the command's final word
   logic [ADDR_W-1:0]   sram_address_reg;
   logic                pend_reg;          // strobe was active last cycle: data arrives now
   logic                pend_last_reg;
   logic                busy_reg;
   logic                done_reg;

   logic [DATA_W-1:0]   fifo_data_reg [FIFO_DEPTH];
   logic                fifo_last_reg [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0]    count_reg;

   logic                cmd_fire;
   logic                push;
   logic                pop;
   logic                final_pop;
   logic [CNT_W-1:0]    count_next;
   logic [CNT_W:0]      occ_next;
   logic                credit_ok;
   logic                issue_next;

   assign cmd_ready       = (state_reg == ST_IDLE) && !reset;
   assign cmd_fire        = cmd_valid && cmd_ready;

   assign out_valid       = (count_reg != '0);
   assign out_data        = fifo_data_reg[rd_ptr_reg];
   assign out_last        = out_valid && fifo_last_reg[rd_ptr_reg];

   assign push            = pend_reg;
   assign pop             = out_valid && out_ready;
   assign final_pop       = pop && out_last;

   assign count_next      = count_reg + {{(CNT_W-1){1'b0}}, push}
                                      - {{(CNT_W-1){1'b0}}, pop};

   // The strobe decided at this edge drives the next cycle. In that cycle the
   // FIFO holds count_next words, and the strobe active now is the one in
   // flight. Both must leave room for the new read.
   assign occ_next        = {1'b0, count_next} + {{CNT_W{1'b0}}, cs_reg};
   assign credit_ok       = occ_next < (CNT_W+1)'(FIFO_DEPTH);
   assign issue_next      = (state_reg == ST_READ) && (remaining_reg != '0) && credit_ok;

   assign sram_address    = sram_address_reg;
   assign sram_chipselect = cs_reg;
   assign sram_write      = 1'b0;
   assign sram_byteenable = '1;
   assign busy            = busy_reg;
   assign done            = done_reg;

   // Command FSM and read issue. All SRAM-side outputs are registered, so the
   // first strobe appears in the cycle after the command handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         addr_reg         <= '0;
         remaining_reg    <= '0;
         cs_reg           <= 1'b0;
         cs_last_reg      <= 1'b0;
         sram_address_reg <= '0;
         pend_reg         <= 1'b0;
         pend_last_reg    <= 1'b0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
      end else begin
         done_reg      <= 1'b0;
         cs_reg        <= 1'b0;
         cs_last_reg   <= 1'b0;
         pend_reg      <= cs_reg;
         pend_last_reg <= cs_last_reg;

         case (state_reg)
            ST_IDLE: begin
               if (cmd_fire) begin
                  if (cmd_len == '0) begin
                     done_reg <= 1'b1;
                  end else begin
                     // The FIFO is empty in IDLE, so the first read always has credit.
                     cs_reg           <= 1'b1;
                     cs_last_reg      <= (cmd_len == LEN_W'(1));
                     sram_address_reg <= cmd_addr;
                     addr_reg         <= cmd_addr + ADDR_W'(1);
                     remaining_reg    <= cmd_len - LEN_W'(1);
                     busy_reg         <= 1'b1;
                     state_reg        <= (cmd_len == LEN_W'(1)) ? ST_DRAIN : ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (issue_next) begin
                  cs_reg           <= 1'b1;
                  cs_last_reg      <= (remaining_reg == LEN_W'(1));
                  sram_address_reg <= addr_reg;
                  addr_reg         <= addr_reg + ADDR_W'(1);   // wraps at the top of memory
                  remaining_reg    <= remaining_reg - LEN_W'(1);
                  if (remaining_reg == LEN_W'(1)) begin
                     state_reg <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // The last-flagged word leaving the FIFO means nothing is left
               // in flight or buffered.
               if (final_pop) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Return buffer. It is small enough to live in registers. Clearing it on
   // reset keeps out_data at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_reg[i] <= '0;
            fifo_last_reg[i] <= 1'b0;
         end
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            fifo_data_reg[wr_ptr_reg] <= sram_readdata;
            fifo_last_reg[wr_ptr_reg] <= pend_last_reg;
            wr_ptr_reg                <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_next;
      end
   end

endmodule
